stg_if: RTL and testbench

- Instruction-fetch stage (stage 2). Sits directly upstream of the decode stage and feeds it a registered pc/instruction pair every cycle.
- Owns the fetch PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO so decode stalls never lose data.
- Handles redirects (taken branches/jumps) by discarding in-flight responses and re-steering the PC.

---
 rtl/stg_if_pkg.sv | 38 +++
 rtl/stg_if_chk.sv | 15 +
 rtl/stg_if_fifo.sv | 58 +++++
 rtl/stg_if.sv | 166 ++++++++++++++++
 tb/tb_stg_if.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stg_if_pkg.sv
// Shared sizes, types and helpers for the instruction-fetch stage (stg_if).
// Holds the sizes.vh definitions (SIZE_ADDR, SIZE_DATA, SIZE_IF_CNT,
// INSTR_NOP), the {pc, instr} word type and a saturating increment used by
// the optional DIAD_IF_PERF_EN counters.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_IF_CNT
`define SIZE_IF_CNT 3
`endif
`ifndef INSTR_NOP
`define INSTR_NOP `SIZE_DATA'b0
`endif

package stg_if_pkg;
    localparam int ADDR_W = `SIZE_ADDR;
    localparam int DATA_W = `SIZE_DATA;
    localparam int CNT_W  = `SIZE_IF_CNT;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_word_t;

    localparam fetch_word_t BUBBLE_WORD = '{pc: {ADDR_W{1'b0}}, instr: `INSTR_NOP};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction
endpackage

// File: rtl/stg_if_chk.sv
// Assertion checker for the fetch buffer.
// Ports: clk, rst, push, pop, full, empty -- all observed FIFO controls.
module stg_if_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
);
    // The credit rule reserves a slot per outstanding request, so a full
    // buffer can only accept a word when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: rtl/stg_if_fifo.sv
// if_fifo: synchronous FIFO of {pc, instr} words for the fetch stage.
// Ports: clk, rst (async, active-high), push/wdata, pop/rdata (head, combinational),
// clear (synchronous flush, wins over push/pop), full, empty, count.
// DEPTH must be 2 or 4 so pointers wrap naturally.
module if_fifo
    import stg_if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_word_t      wdata,
    output fetch_word_t      rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;

    fetch_word_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    assign rdata = mem[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
            count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Word storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= BUBBLE_WORD;
        end else if (push && !clear) begin
            mem[wr_ptr_r] <= wdata;
        end
    end
endmodule

// File: rtl/stg_if.sv
// stg_if: instruction-fetch stage. Issues in-order word fetches over a
// req/gnt/rvalid handshake, buffers responses in if_fifo, and presents a
// registered {pc, instr, valid} to decode every cycle. Redirects flush the
// buffer and mark every in-flight response for discard.
// Ports: iw_clk, iw_rst (async active-high); ow_imem_req/ow_imem_addr,
// iw_imem_gnt, iw_imem_rvalid/iw_imem_rdata (memory side); iw_stall,
// iw_redirect/iw_redirect_pc (control); ow_pc/ow_instr/ow_valid (to decode).
// Optional macro DIAD_IF_PERF_EN adds ow_bubble_cnt and ow_redirect_cnt.
module stg_if
    import stg_if_pkg::*;
#(
    parameter logic [`SIZE_ADDR-1:0] RESET_PC   = {`SIZE_ADDR{1'b0}},
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    output logic                  ow_imem_req,
    output logic [`SIZE_ADDR-1:0] ow_imem_addr,
    input  logic                  iw_imem_gnt,
    input  logic                  iw_imem_rvalid,
    input  logic [`SIZE_DATA-1:0] iw_imem_rdata,
    input  logic                  iw_stall,
    input  logic                  iw_redirect,
    input  logic [`SIZE_ADDR-1:0] iw_redirect_pc,
    output logic [`SIZE_ADDR-1:0] ow_pc,
    output logic [`SIZE_DATA-1:0] ow_instr,
    output logic                  ow_valid
`ifdef DIAD_IF_PERF_EN
    ,
    output logic [31:0]           ow_bubble_cnt,
    output logic [31:0]           ow_redirect_cnt
`endif
);
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W+1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] resp_pc_r;
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  drop_r;
    fetch_word_t       out_r;
    logic              valid_r;

    fetch_word_t       out_next_s;
    logic              valid_next_s;
    fetch_word_t       resp_word_s;
    fetch_word_t       fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              grant_s;
    logic              tagged_s;
    logic              bypass_s;
    logic              push_s;
    logic              pop_s;

    // Every outstanding request owns a buffer slot, so the buffer never overflows.
    assign ow_imem_req  = !iw_rst && !iw_redirect &&
                          (({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < CREDIT_LIMIT);
    assign ow_imem_addr = fetch_pc_r;
    assign grant_s      = ow_imem_req && iw_imem_gnt;
    assign tagged_s     = iw_imem_rvalid && (drop_r == {CNT_W{1'b0}}) && !iw_redirect;
    assign bypass_s     = tagged_s && fifo_empty_s && !iw_stall;
    assign push_s       = tagged_s && !bypass_s;
    assign pop_s        = !iw_redirect && !iw_stall && !fifo_empty_s;
    assign resp_word_s  = '{pc: resp_pc_r, instr: iw_imem_rdata};

    if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (iw_clk),
        .rst   (iw_rst),
        .push  (push_s),
        .pop   (pop_s),
        .clear (iw_redirect),
        .wdata (resp_word_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    stg_if_chk u_chk (
        .clk   (iw_clk),
        .rst   (iw_rst),
        .push  (push_s && !iw_redirect),
        .pop   (pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Fetch/response PCs and the in-flight and discard counters.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            drop_r        <= {CNT_W{1'b0}};
        end else if (iw_redirect) begin
            fetch_pc_r    <= iw_redirect_pc;
            resp_pc_r     <= iw_redirect_pc;
            // outstanding_r already includes words marked for discard, so
            // every response still in flight (minus one landing now) is stale.
            outstanding_r <= outstanding_r - CNT_W'(iw_imem_rvalid);
            drop_r        <= outstanding_r - CNT_W'(iw_imem_rvalid);
        end else begin
            if (grant_s) fetch_pc_r <= fetch_pc_r + 1'b1;
            if (tagged_s) resp_pc_r <= resp_pc_r + 1'b1;
            if (iw_imem_rvalid && (drop_r != {CNT_W{1'b0}})) drop_r <= drop_r - 1'b1;
            outstanding_r <= outstanding_r + CNT_W'(grant_s) - CNT_W'(iw_imem_rvalid);
        end
    end

    // Next value of the decode-facing register: redirect > stall > buffer head > bypass > bubble.
    always_comb begin
        out_next_s   = out_r;
        valid_next_s = valid_r;
        if (iw_redirect) begin
            out_next_s   = BUBBLE_WORD;
            valid_next_s = 1'b0;
        end else if (iw_stall) begin
            out_next_s   = out_r;
            valid_next_s = valid_r;
        end else if (!fifo_empty_s) begin
            out_next_s   = fifo_head_s;
            valid_next_s = 1'b1;
        end else if (bypass_s) begin
            out_next_s   = resp_word_s;
            valid_next_s = 1'b1;
        end else begin
            out_next_s   = BUBBLE_WORD;
            valid_next_s = 1'b0;
        end
    end

    // Decode-facing output register.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            out_r   <= BUBBLE_WORD;
            valid_r <= 1'b0;
        end else begin
            out_r   <= out_next_s;
            valid_r <= valid_next_s;
        end
    end

    assign ow_pc    = out_r.pc;
    assign ow_instr = out_r.instr;
    assign ow_valid = valid_r;

`ifdef DIAD_IF_PERF_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] redirect_cnt_r;

    // Saturating counts of unstalled bubble cycles and of redirects.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            bubble_cnt_r   <= 32'd0;
            redirect_cnt_r <= 32'd0;
        end else begin
            if (!iw_stall && !valid_r) bubble_cnt_r <= sat_inc32(bubble_cnt_r);
            if (iw_redirect) redirect_cnt_r <= sat_inc32(redirect_cnt_r);
        end
    end

    assign ow_bubble_cnt   = bubble_cnt_r;
    assign ow_redirect_cnt = redirect_cnt_r;
`endif
endmodule

// File: tb/tb_stg_if.sv
// Self-checking bench for stg_if (RESET_PC=0x10, FIFO_DEPTH=2). A memory
// model answers granted requests in order after a random latency with
// rdata = addr ^ 0xA5. The reference model tracks in-flight requests (marked
// stale on redirect) and a queue of fetched-but-unpresented words; decode
// sees the head of that queue whenever it is not stalled.
module tb_stg_if;
    import stg_if_pkg::*;

    localparam logic [ADDR_W-1:0] RST_PC = 32'h0000_0010;
    localparam int DEPTH = 2;

    logic              iw_clk = 1'b0;
    logic              iw_rst = 1'b1;
    logic              ow_imem_req;
    logic [ADDR_W-1:0] ow_imem_addr;
    logic              iw_imem_gnt = 1'b0;
    logic              iw_imem_rvalid = 1'b0;
    logic [DATA_W-1:0] iw_imem_rdata = '0;
    logic              iw_stall = 1'b0;
    logic              iw_redirect = 1'b0;
    logic [ADDR_W-1:0] iw_redirect_pc = '0;
    logic [ADDR_W-1:0] ow_pc;
    logic [DATA_W-1:0] ow_instr;
    logic              ow_valid;
`ifdef DIAD_IF_PERF_EN
    logic [31:0]       ow_bubble_cnt;
    logic [31:0]       ow_redirect_cnt;
`endif

    stg_if #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .ow_imem_req(ow_imem_req), .ow_imem_addr(ow_imem_addr),
        .iw_imem_gnt(iw_imem_gnt), .iw_imem_rvalid(iw_imem_rvalid),
        .iw_imem_rdata(iw_imem_rdata), .iw_stall(iw_stall),
        .iw_redirect(iw_redirect), .iw_redirect_pc(iw_redirect_pc),
        .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_valid(ow_valid)
`ifdef DIAD_IF_PERF_EN
        , .ow_bubble_cnt(ow_bubble_cnt), .ow_redirect_cnt(ow_redirect_cnt)
`endif
    );

    always #5 iw_clk = ~iw_clk;

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;
    int gnt_pct = 100, rv_pct = 100, max_lat = 1;

    // memory / model state
    logic [ADDR_W-1:0] q_addr[$];
    int unsigned       q_ready[$];
    bit                q_stale[$];
    logic [ADDR_W-1:0] buffered[$];
    logic [ADDR_W-1:0] fetch_pc;
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_pc;
    logic [DATA_W-1:0] exp_instr;
    logic              exp_req, obs_req;
    logic [ADDR_W-1:0] exp_addr, obs_addr;
    logic [31:0]       exp_bub, exp_red;

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ 32'h0000_00A5;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        q_addr.delete(); q_ready.delete(); q_stale.delete(); buffered.delete();
        fetch_pc = RST_PC;
        exp_valid = 1'b0; exp_pc = '0; exp_instr = '0;
        exp_bub = 32'd0; exp_red = 32'd0;
    endtask

    // One clock: drive inputs at negedge, sample combinational req, advance model at posedge.
    task automatic step(input logic stall, input logic redir, input logic [ADDR_W-1:0] rpc);
        int unsigned lat;
        iw_stall = stall; iw_redirect = redir; iw_redirect_pc = rpc;
        iw_imem_gnt = ($urandom_range(99, 0) < gnt_pct);
        if (q_addr.size() > 0 && q_ready[0] <= cyc && $urandom_range(99, 0) < rv_pct) begin
            iw_imem_rvalid = 1'b1;
            iw_imem_rdata = word_of(q_addr[0]);
        end else begin
            iw_imem_rvalid = 1'b0;
            iw_imem_rdata = $urandom;
        end
        #1;
        exp_req = !redir && ((q_addr.size() + buffered.size()) < DEPTH);
        exp_addr = fetch_pc;
        obs_req = ow_imem_req;
        obs_addr = ow_imem_addr;
        if (!stall && !exp_valid) exp_bub = sat(exp_bub);
        if (redir) exp_red = sat(exp_red);
        @(posedge iw_clk);
        if (iw_imem_rvalid) begin
            if (!q_stale[0] && !redir) buffered.push_back(q_addr[0]);
            void'(q_addr.pop_front()); void'(q_ready.pop_front()); void'(q_stale.pop_front());
        end
        if (redir) begin
            foreach (q_stale[i]) q_stale[i] = 1'b1;
            buffered.delete();
            exp_valid = 1'b0; exp_pc = '0; exp_instr = '0;
            fetch_pc = rpc;
        end else begin
            if (obs_req && iw_imem_gnt) begin
                lat = $urandom_range(max_lat, 1);
                q_addr.push_back(obs_addr); q_ready.push_back(cyc + lat); q_stale.push_back(1'b0);
                fetch_pc = fetch_pc + 1'b1;
            end
            if (!stall) begin
                if (buffered.size() > 0) begin
                    exp_pc = buffered.pop_front();
                    exp_valid = 1'b1;
                    exp_instr = word_of(exp_pc);
                end else begin
                    exp_valid = 1'b0; exp_pc = '0; exp_instr = '0;
                end
            end
        end
        cyc++;
        @(negedge iw_clk);
    endtask

    task automatic test_reset();
        iw_rst = 1'b1;
        @(negedge iw_clk); @(negedge iw_clk);
        total++;
        if ({ow_valid, ow_pc, ow_instr, ow_imem_req} !== {1'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got v=%0d pc=%h instr=%h req=%0d want all zero", ow_valid, ow_pc, ow_instr, ow_imem_req);
        end
        total++;
        if (ow_imem_addr !== RST_PC) begin
            bad++;
            $display("FAIL reset_addr got %h want %h", ow_imem_addr, RST_PC);
        end
        iw_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        logic seen = 1'b0;
        logic [ADDR_W-1:0] first_pc = '0;
        gnt_pct = 100; rv_pct = 100; max_lat = 1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, '0);
            if (ow_valid && !seen) begin seen = 1'b1; first_pc = ow_pc; end
            total++;
            if ({ow_valid, ow_pc, ow_instr} !== {exp_valid, exp_pc, exp_instr}) begin
                bad++;
                $display("FAIL stream cyc=%0d got v=%0d pc=%h i=%h want v=%0d pc=%h i=%h", cyc, ow_valid, ow_pc, ow_instr, exp_valid, exp_pc, exp_instr);
            end
            total++;
            if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
                bad++;
                $display("FAIL stream_req cyc=%0d got req=%0d addr=%h want req=%0d addr=%h", cyc, obs_req, obs_addr, exp_req, exp_addr);
            end
        end
        total++;
        if (first_pc !== RST_PC) begin
            bad++;
            $display("FAIL first_pc got %h want %h", first_pc, RST_PC);
        end
    endtask

    task automatic test_stall();
        gnt_pct = 100; rv_pct = 100; max_lat = 1;
        for (int i = 0; i < 10; i++) begin
            step((i >= 2 && i < 5), 1'b0, '0);
            total++;
            if ({ow_valid, ow_pc, ow_instr} !== {exp_valid, exp_pc, exp_instr}) begin
                bad++;
                $display("FAIL stall cyc=%0d got v=%0d pc=%h i=%h want v=%0d pc=%h i=%h", cyc, ow_valid, ow_pc, ow_instr, exp_valid, exp_pc, exp_instr);
            end
            total++;
            if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
                bad++;
                $display("FAIL stall_req cyc=%0d got req=%0d addr=%h want req=%0d addr=%h", cyc, obs_req, obs_addr, exp_req, exp_addr);
            end
        end
    endtask

    // Redirect with two responses outstanding, then redirect together with stall and rvalid.
    task automatic test_redirect();
        gnt_pct = 100; max_lat = 1;
        for (int i = 0; i < 24; i++) begin
            rv_pct = (i == 2 || i == 3 || i == 13 || i == 14) ? 0 : 100;
            if (i == 4) step(1'b0, 1'b1, 32'h0000_0040);
            else if (i == 15) step(1'b1, 1'b1, 32'h0000_0080);
            else step(1'b0, 1'b0, '0);
            total++;
            if ({ow_valid, ow_pc, ow_instr} !== {exp_valid, exp_pc, exp_instr}) begin
                bad++;
                $display("FAIL redirect cyc=%0d got v=%0d pc=%h i=%h want v=%0d pc=%h i=%h", cyc, ow_valid, ow_pc, ow_instr, exp_valid, exp_pc, exp_instr);
            end
            total++;
            if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
                bad++;
                $display("FAIL redirect_req cyc=%0d got req=%0d addr=%h want req=%0d addr=%h", cyc, obs_req, obs_addr, exp_req, exp_addr);
            end
            if (i >= 4 && ow_valid) begin
                total++;
                if (ow_pc < 32'h0000_0040) begin
                    bad++;
                    $display("FAIL stale_pc cyc=%0d got pc=%h want >= 00000040", cyc, ow_pc);
                end
            end
        end
    endtask

    // Withheld grant, then fetch across the top of the address space.
    task automatic test_gnt_wrap();
        logic saw_zero = 1'b0;
        rv_pct = 100; max_lat = 1;
        for (int i = 0; i < 16; i++) begin
            gnt_pct = (i < 5) ? 0 : 100;
            step(1'b0, (i == 6), {ADDR_W{1'b1}} - 32'd1);
            if (ow_valid && ow_pc == '0) saw_zero = 1'b1;
            total++;
            if ({ow_valid, ow_pc, ow_instr} !== {exp_valid, exp_pc, exp_instr}) begin
                bad++;
                $display("FAIL gnt_wrap cyc=%0d got v=%0d pc=%h i=%h want v=%0d pc=%h i=%h", cyc, ow_valid, ow_pc, ow_instr, exp_valid, exp_pc, exp_instr);
            end
            total++;
            if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
                bad++;
                $display("FAIL gnt_wrap_req cyc=%0d got req=%0d addr=%h want req=%0d addr=%h", cyc, obs_req, obs_addr, exp_req, exp_addr);
            end
        end
        total++;
        if (saw_zero !== 1'b1) begin
            bad++;
            $display("FAIL wrap_zero got seen=%0d want 1", saw_zero);
        end
    endtask

    task automatic test_random();
        gnt_pct = 70; rv_pct = 70; max_lat = 3;
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(99, 0) < 25), ($urandom_range(99, 0) < 4), $urandom);
            total++;
            if ({ow_valid, ow_pc, ow_instr} !== {exp_valid, exp_pc, exp_instr}) begin
                bad++;
                $display("FAIL random cyc=%0d got v=%0d pc=%h i=%h want v=%0d pc=%h i=%h", cyc, ow_valid, ow_pc, ow_instr, exp_valid, exp_pc, exp_instr);
            end
            total++;
            if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
                bad++;
                $display("FAIL random_req cyc=%0d got req=%0d addr=%h want req=%0d addr=%h", cyc, obs_req, obs_addr, exp_req, exp_addr);
            end
`ifdef DIAD_IF_PERF_EN
            total++;
            if ({ow_bubble_cnt, ow_redirect_cnt} !== {exp_bub, exp_red}) begin
                bad++;
                $display("FAIL perf cyc=%0d got bub=%0d red=%0d want bub=%0d red=%0d", cyc, ow_bubble_cnt, ow_redirect_cnt, exp_bub, exp_red);
            end
`endif
        end
    endtask

    // Asynchronous reset in the middle of a cycle clears outputs at once.
    task automatic test_reset_mid();
        gnt_pct = 100; rv_pct = 100; max_lat = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        #2 iw_rst = 1'b1;
        #1;
        total++;
        if ({ow_valid, ow_pc, ow_instr, ow_imem_req} !== {1'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid got v=%0d pc=%h i=%h req=%0d want all zero", ow_valid, ow_pc, ow_instr, ow_imem_req);
        end
`ifdef DIAD_IF_PERF_EN
        total++;
        if ({ow_bubble_cnt, ow_redirect_cnt} !== 64'd0) begin
            bad++;
            $display("FAIL perf_reset got bub=%0d red=%0d want 0 0", ow_bubble_cnt, ow_redirect_cnt);
        end
`endif
        iw_imem_rvalid = 1'b0;
        @(negedge iw_clk);
        iw_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, '0);
            total++;
            if ({ow_valid, ow_pc, ow_instr} !== {exp_valid, exp_pc, exp_instr}) begin
                bad++;
                $display("FAIL after_reset cyc=%0d got v=%0d pc=%h i=%h want v=%0d pc=%h i=%h", cyc, ow_valid, ow_pc, ow_instr, exp_valid, exp_pc, exp_instr);
            end
        end
    endtask

`ifdef DIAD_IF_PERF_EN
    // Four unstalled bubble cycles, then two redirects under stall.
    task automatic test_perf();
        iw_rst = 1'b1;
        @(negedge iw_clk);
        iw_rst = 1'b0;
        model_reset();
        gnt_pct = 0; rv_pct = 100; max_lat = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 32'h0000_0100);
        total++;
        if ({ow_bubble_cnt, ow_redirect_cnt} !== {32'd4, 32'd2}) begin
            bad++;
            $display("FAIL perf_counts got bub=%0d red=%0d want bub=4 red=2", ow_bubble_cnt, ow_redirect_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_gnt_wrap();
        test_random();
        test_reset_mid();
`ifdef DIAD_IF_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
